obi_mem_arbiter: RTL and testbench

//  Shares one memory port between the core instruction and data OBI-style ports (req/gnt/rvalid).

---
 rtl/obi_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_obi_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// Two-port OBI arbiter: instruction and data ports share one memory port.
// Round-robin with request lock; an ID FIFO routes in-order responses.
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   instr_req/addr_i, instr_gnt/rvalid/rdata_o       instruction port
//   data_req/addr/we/be/wdata_i, data_gnt/rvalid/rdata_o  data port
//   mem_req/addr/we/be/wdata_o, mem_gnt/rvalid/rdata_i    memory port
//   busy_o   transactions outstanding
//   err_o    sticky: memory response with nothing outstanding
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [CW-1:0]              r_cnt;
    logic                       r_lock;
    logic                       r_owner;
    logic                       r_last;
    logic                       r_err;

    logic w_winner;
    logic w_full;
    logic w_hs;
    logic w_pop;
    logic w_head;

    // Lock keeps the memory-side request stable until it is granted.
    // A tie goes to the port that did not win last; r_last resets to
    // DATA so the first tie favours INSTR.
    always_comb begin
        w_winner = ID_I;
        if (r_lock)
            w_winner = r_owner;
        else if (instr_req_i && data_req_i)
            w_winner = ~r_last;
        else if (data_req_i)
            w_winner = ID_D;
    end

    assign w_full    = (r_cnt == CNT_MAX);
    // Full blocks the request even if a response pops this cycle.
    assign mem_req_o = rst_ni & (instr_req_i | data_req_i) & ~w_full;

    assign mem_addr_o  = w_winner ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = w_winner & data_we_i;
    assign mem_be_o    = w_winner ? data_be_i    : '1;
    assign mem_wdata_o = w_winner ? data_wdata_i : '0;

    assign w_hs        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = w_hs & (w_winner == ID_I);
    assign data_gnt_o  = w_hs & (w_winner == ID_D);

    assign w_head         = r_fifo[r_rptr];
    assign w_pop          = mem_rvalid_i & (r_cnt != '0);
    assign instr_rvalid_o = w_pop & (w_head == ID_I);
    assign data_rvalid_o  = w_pop & (w_head == ID_D);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign busy_o = (r_cnt != '0);
    assign err_o  = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_lock  <= 1'b0;
            r_owner <= ID_I;
            r_last  <= ID_D;
            r_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_fifo[r_wptr] <= w_winner;
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
                r_last <= w_winner;
                r_lock <= 1'b0;
            end else if (mem_req_o) begin
                r_lock  <= 1'b1;
                r_owner <= w_winner;
            end
            if (w_pop)
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);
            if (w_hs && !w_pop)
                r_cnt <= r_cnt + CW'(1);
            else if (!w_hs && w_pop)
                r_cnt <= r_cnt - CW'(1);
            if (mem_rvalid_i && r_cnt == '0)
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter with a response scoreboard.
// Expected port IDs and read data are queued at grant time.
module tb_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq, dreq, dwe, mgnt, mrv;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dbe;
    logic        igEnt_unused;
    logic        igt, irv, dgt, drv, mreq, mwe, busy, err;
    logic [31:0] ird, drd, maddr, mwdata;
    logic [3:0]  mbe;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic last;

    always #5 clk = ~clk;

    obi_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(ireq), .instr_addr_i(iaddr),
        .instr_gnt_o(igt), .instr_rvalid_o(irv), .instr_rdata_o(ird),
        .data_req_i(dreq), .data_addr_i(daddr), .data_we_i(dwe),
        .data_be_i(dbe), .data_wdata_i(dwdata),
        .data_gnt_o(dgt), .data_rvalid_o(drv), .data_rdata_o(drd),
        .mem_req_o(mreq), .mem_addr_o(maddr), .mem_we_o(mwe),
        .mem_be_o(mbe), .mem_wdata_o(mwdata),
        .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata),
        .busy_o(busy), .err_o(err)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ireq = 0; dreq = 0; dwe = 0; mgnt = 0; mrv = 0;
        iaddr = 0; daddr = 0; dwdata = 0; dbe = 0; mrdata = 0;
    endtask

    // Check routed response against the scoreboard head.
    task automatic resp(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, irv %0b drv %0b", tag, irv, drv);
        end else begin
            e = sb.pop_front();
            chk({tag, "_irv"}, 32'(irv), 32'(e.id == 1'b0));
            chk({tag, "_drv"}, 32'(drv), 32'(e.id == 1'b1));
            chk({tag, "_rd"}, e.id ? drd : ird, e.rdata);
        end
    endtask

    function automatic logic [31:0] head_rdata();
        return (sb.size() != 0) ? sb[0].rdata : 32'hBAD0BAD0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        #1;
        sb.delete();
        last = 1'b1;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        last = 1'b1;
        #2;
        chk("rst_mreq", 32'(mreq), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_gnt", 32'({igt, dgt}), 0);
        chk("rst_rv", 32'({irv, drv}), 0);
        @(negedge clk);
        rst_n = 1;

        // Instruction fetch, same-cycle grant, response next cycle
        @(negedge clk);
        ireq = 1; iaddr = 32'h80; mgnt = 1;
        #1;
        chk("t1_igt", 32'(igt), 1);
        chk("t1_dgt", 32'(dgt), 0);
        chk("t1_addr", maddr, 32'h80);
        chk("t1_we", 32'(mwe), 0);
        chk("t1_be", 32'(mbe), 32'hF);
        chk("t1_wd", mwdata, 0);
        sb.push_back('{1'b0, 32'h13});
        @(negedge clk);
        idle();
        mrv = 1; mrdata = 32'h13;
        #1;
        chk("t1_busy", 32'(busy), 1);
        resp("t1_resp");
        @(negedge clk);
        idle();
        #1;
        chk("t1_idle", 32'(busy), 0);

        // Both ports request continuously: alternate starting INSTR
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic w;
            @(negedge clk);
            ireq = 1; dreq = 1; iaddr = 32'h200 + 32'(i);
            daddr = 32'h3000 + 32'(i); mgnt = 1;
            mrv = (i > 0); mrdata = head_rdata();
            #1;
            w = ~last;
            last = w;
            chk($sformatf("t2_igt%0d", i), 32'(igt), 32'(w == 1'b0));
            chk($sformatf("t2_dgt%0d", i), 32'(dgt), 32'(w == 1'b1));
            chk($sformatf("t2_addr%0d", i), maddr,
                w ? 32'h3000 + 32'(i) : 32'h200 + 32'(i));
            if (i > 0) resp($sformatf("t2_resp%0d", i));
            sb.push_back('{w, 32'hA0 + 32'(i)});
        end
        @(negedge clk);
        idle();
        mrv = 1; mrdata = head_rdata();
        #1;
        resp("t2_last");

        // Data write stalled 3 cycles; instr request must not disturb it
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dreq = 1; dwe = 1; daddr = 32'h1000; dbe = 4'b0011;
            dwdata = 32'hDEADBEEF; mgnt = (i == 3);
            ireq = (i >= 1); iaddr = 32'h44;
            #1;
            chk($sformatf("t3_addr%0d", i), maddr, 32'h1000);
            chk($sformatf("t3_we%0d", i), 32'(mwe), 1);
            chk($sformatf("t3_be%0d", i), 32'(mbe), 32'h3);
            chk($sformatf("t3_wd%0d", i), mwdata, 32'hDEADBEEF);
            chk($sformatf("t3_dgt%0d", i), 32'(dgt), 32'(i == 3));
            chk($sformatf("t3_igt%0d", i), 32'(igt), 0);
        end
        sb.push_back('{1'b1, 32'h0});
        @(negedge clk);
        idle();
        ireq = 1; iaddr = 32'h44; mgnt = 1;
        mrv = 1; mrdata = head_rdata();
        #1;
        chk("t3_igt", 32'(igt), 1);
        chk("t3_iaddr", maddr, 32'h44);
        chk("t3_iwe", 32'(mwe), 0);
        resp("t3_wresp");
        sb.push_back('{1'b0, 32'h55});
        @(negedge clk);
        idle();
        mrv = 1; mrdata = head_rdata();
        #1;
        resp("t3_iresp");

        // Outstanding limit: full blocks requests even with a pop
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ireq = 1; iaddr = 32'h10 * 32'(i); mgnt = 1;
            #1;
            chk($sformatf("t4_igt%0d", i), 32'(igt), 1);
            sb.push_back('{1'b0, 32'hC0 + 32'(i)});
        end
        @(negedge clk);
        #1;
        chk("t4_full_req", 32'(mreq), 0);
        chk("t4_full_gnt", 32'(igt), 0);
        chk("t4_busy", 32'(busy), 1);
        @(negedge clk);
        mrv = 1; mrdata = head_rdata();
        #1;
        chk("t4_pop_req", 32'(mreq), 0);
        chk("t4_pop_gnt", 32'(igt), 0);
        resp("t4_resp0");
        @(negedge clk);
        mrdata = head_rdata();
        #1;
        chk("t4_next_gnt", 32'(igt), 1);
        resp("t4_resp1");
        sb.push_back('{1'b0, 32'hC2});
        @(negedge clk);
        idle();
        mrv = 1; mrdata = head_rdata();
        #1;
        resp("t4_resp2");
        @(negedge clk);
        idle();
        #1;
        chk("t4_drained", 32'(busy), 0);

        // Unsolicited response sets sticky error
        @(negedge clk);
        mrv = 1; mrdata = 32'h77;
        #1;
        chk("t5_rv", 32'({irv, drv}), 0);
        chk("t5_err_pre", 32'(err), 0);
        @(negedge clk);
        idle();
        #1;
        chk("t5_err", 32'(err), 1);
        chk("t5_busy", 32'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t5_err_hold", 32'(err), 1);
        #1;
        rst_n = 0;
        #1;
        chk("t5_err_clr", 32'(err), 0);
        @(negedge clk);
        rst_n = 1;

        // Asynchronous reset with two outstanding transactions
        last = 1'b1;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ireq = 1; dreq = 1; mgnt = 1; iaddr = 32'h600; daddr = 32'h700;
            #1;
            chk($sformatf("t6_gnt%0d", i), 32'({igt, dgt}),
                (i == 0) ? 32'h2 : 32'h1);
        end
        @(negedge clk);
        #2;
        chk("t6_full", 32'(busy), 1);
        rst_n = 0;
        #1;
        chk("t6_req", 32'(mreq), 0);
        chk("t6_gnt", 32'({igt, dgt}), 0);
        chk("t6_busy", 32'(busy), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("t6_tie_i", 32'({igt, dgt}), 32'h2);
        sb.push_back('{1'b0, 32'hE1});
        @(negedge clk);
        idle();
        mrv = 1; mrdata = head_rdata();
        #1;
        resp("t6_resp");
        @(negedge clk);
        mrv = 1; mrdata = 32'h99;
        #1;
        chk("t6_late_rv", 32'({irv, drv}), 0);
        @(negedge clk);
        idle();
        #1;
        chk("t6_late_err", 32'(err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
